// File: rtl/am2901_slice_n.sv
// Parametrised Am2901-style bit slice: ALU, dual-read register file, Q register and shifters.
// PIPE=1 adds one register stage on y and the flags; RAM/Q writes stay same-cycle.
module am2901_slice_n #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned PIPE   = 0
) (
  input  logic              cp,
  input  logic              reset,
  input  logic [8:0]        i,
  input  logic              iv,
  input  logic              cin,
  input  logic [WIDTH-1:0]  d,
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] b,
  input  logic              oe,
  output wire  [WIDTH-1:0]  y,
  output logic              cout,
  output logic              ovr,
  output logic              z,
  output logic              f_msb,
  output logic              g_lo,
  output logic              p_lo,
  inout  wire               ram0,
  inout  wire               ram_msb,
  inout  wire               q0,
  inout  wire               q_msb
);
  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [WIDTH-1:0] ram_q [Depth];
  logic [WIDTH-1:0] ram_d [Depth];
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] a_val, b_val, r_op, s_op, x_op, y_op, f, y_val, y_out;
  logic [WIDTH-1:0] gen, prop, ram_wdata, q_wdata;
  logic [WIDTH:0]   sum;
  logic [2:0]       src, fn, dst;
  logic             arith, grp_gen, c_msb, shift_dn, shift_up, ram_we, q_we;
  logic [5:0]       flg_d;

  assign src      = i[2:0];
  assign fn       = i[5:3];
  assign dst      = i[8:6];
  assign a_val    = ram_q[a];
  assign b_val    = ram_q[b];
  assign shift_dn = (dst[2:1] == 2'b10);
  assign shift_up = (dst[2:1] == 2'b11);

  always_comb begin
    r_op = '0;
    s_op = '0;
    case (src)
      3'd0:    begin r_op = a_val; s_op = q_q;   end
      3'd1:    begin r_op = a_val; s_op = b_val; end
      3'd2:    begin r_op = '0;    s_op = q_q;   end
      3'd3:    begin r_op = '0;    s_op = b_val; end
      3'd4:    begin r_op = '0;    s_op = a_val; end
      3'd5:    begin r_op = d;     s_op = a_val; end
      3'd6:    begin r_op = d;     s_op = q_q;   end
      default: begin r_op = d;     s_op = '0;    end
    endcase
  end

  // Operands as actually presented to the adder; lookahead terms use these.
  always_comb begin
    x_op = r_op;
    y_op = s_op;
    if (fn == 3'd1) x_op = ~r_op;
    if (fn == 3'd2) y_op = ~s_op;
  end

  assign arith = (fn < 3'd3);
  assign sum   = {1'b0, x_op} + {1'b0, y_op} + {{WIDTH{1'b0}}, cin};
  assign gen   = x_op & y_op;
  assign prop  = x_op | y_op;
  assign c_msb = x_op[WIDTH-1] ^ y_op[WIDTH-1] ^ sum[WIDTH-1];

  always_comb begin
    grp_gen = 1'b0;
    for (int unsigned k = 0; k < WIDTH; k++) grp_gen = gen[k] | (prop[k] & grp_gen);
  end

  always_comb begin
    f = sum[WIDTH-1:0];
    case (fn)
      3'd3:    f = r_op | s_op;
      3'd4:    f = r_op & s_op;
      3'd5:    f = ~r_op & s_op;
      3'd6:    f = r_op ^ s_op;
      3'd7:    f = ~(r_op ^ s_op);
      default: f = sum[WIDTH-1:0];
    endcase
  end

  assign flg_d = {arith & sum[WIDTH], arith & (c_msb ^ sum[WIDTH]), (f == '0), f[WIDTH-1],
                  ~(arith & grp_gen), ~(arith & (&prop))};

  always_comb begin
    ram_we    = 1'b0;
    ram_wdata = f;
    q_we      = 1'b0;
    q_wdata   = f;
    y_val     = f;
    case (dst)
      3'd0: q_we = 1'b1;
      3'd2: begin ram_we = 1'b1; y_val = a_val; end
      3'd3: ram_we = 1'b1;
      3'd4: begin
        ram_we    = 1'b1;
        ram_wdata = {ram_msb, f[WIDTH-1:1]};
        q_we      = 1'b1;
        q_wdata   = {q_msb, q_q[WIDTH-1:1]};
      end
      3'd5: begin ram_we = 1'b1; ram_wdata = {ram_msb, f[WIDTH-1:1]}; end
      3'd6: begin
        ram_we    = 1'b1;
        ram_wdata = {f[WIDTH-2:0], ram0};
        q_we      = 1'b1;
        q_wdata   = {q_q[WIDTH-2:0], q0};
      end
      3'd7: begin ram_we = 1'b1; ram_wdata = {f[WIDTH-2:0], ram0}; end
      default: ;
    endcase
  end

  always_comb begin
    ram_d = ram_q;
    q_d   = q_q;
    if (iv) begin
      if (ram_we) ram_d[b] = ram_wdata;
      if (q_we)   q_d      = q_wdata;
    end
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      ram_q <= '{default: '0};
      q_q   <= '0;
    end else begin
      ram_q <= ram_d;
      q_q   <= q_d;
    end
  end

  assign ram0    = shift_dn ? f[0]          : 1'bz;
  assign q0      = shift_dn ? q_q[0]        : 1'bz;
  assign ram_msb = shift_up ? f[WIDTH-1]    : 1'bz;
  assign q_msb   = shift_up ? q_q[WIDTH-1]  : 1'bz;

  if (PIPE != 0) begin : g_pipe
    logic [WIDTH-1:0] y_pq;
    logic [5:0]       flg_q;
    // Group generate/propagate are active-low, so their idle value is 1.
    always_ff @(posedge cp) begin
      if (reset) begin
        y_pq  <= '0;
        flg_q <= 6'b000011;
      end else begin
        y_pq  <= y_val;
        flg_q <= flg_d;
      end
    end
    assign y_out = y_pq;
    assign {cout, ovr, z, f_msb, g_lo, p_lo} = flg_q;
  end else begin : g_comb
    assign y_out = y_val;
    assign {cout, ovr, z, f_msb, g_lo, p_lo} = flg_d;
  end

  assign y = oe ? {WIDTH{1'bz}} : y_out;

endmodule

// File: tb/tb_am2901_slice_n.sv
// Bench for am2901_slice_n: a combinational (PIPE=0) and a registered (PIPE=1) instance share
// stimulus; an arithmetic model predicts y, flags and shifter pins every cycle.
module tb_am2901_slice_n;
  logic       cp = 1'b0;
  logic       reset, iv, cin, oe;
  logic [8:0] i;
  logic [7:0] d;
  logic [3:0] a, b;
  logic       tb_ram0, tb_ram_msb, tb_q0, tb_q_msb;

  wire [7:0] y0, y1;
  wire cout0, ovr0, z0, fmsb0, glo0, plo0;
  wire cout1, ovr1, z1, fmsb1, glo1, plo1;
  wire ram0_0, ram_msb_0, q0_0, q_msb_0;
  wire ram0_1, ram_msb_1, q0_1, q_msb_1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 cp = ~cp;

  // The bench drives whichever shifter ends the current destination treats as inputs.
  assign ram_msb_0 = (i[8:7] == 2'b10) ? tb_ram_msb : 1'bz;
  assign q_msb_0   = (i[8:7] == 2'b10) ? tb_q_msb   : 1'bz;
  assign ram0_0    = (i[8:7] == 2'b11) ? tb_ram0    : 1'bz;
  assign q0_0      = (i[8:7] == 2'b11) ? tb_q0      : 1'bz;
  assign ram_msb_1 = (i[8:7] == 2'b10) ? tb_ram_msb : 1'bz;
  assign q_msb_1   = (i[8:7] == 2'b10) ? tb_q_msb   : 1'bz;
  assign ram0_1    = (i[8:7] == 2'b11) ? tb_ram0    : 1'bz;
  assign q0_1      = (i[8:7] == 2'b11) ? tb_q0      : 1'bz;

  am2901_slice_n #(.WIDTH(8), .ADDR_W(4), .PIPE(0)) dut0 (
    .cp(cp), .reset(reset), .i(i), .iv(iv), .cin(cin), .d(d), .a(a), .b(b), .oe(oe),
    .y(y0), .cout(cout0), .ovr(ovr0), .z(z0), .f_msb(fmsb0), .g_lo(glo0), .p_lo(plo0),
    .ram0(ram0_0), .ram_msb(ram_msb_0), .q0(q0_0), .q_msb(q_msb_0)
  );

  am2901_slice_n #(.WIDTH(8), .ADDR_W(4), .PIPE(1)) dut1 (
    .cp(cp), .reset(reset), .i(i), .iv(iv), .cin(cin), .d(d), .a(a), .b(b), .oe(oe),
    .y(y1), .cout(cout1), .ovr(ovr1), .z(z1), .f_msb(fmsb1), .g_lo(glo1), .p_lo(plo1),
    .ram0(ram0_1), .ram_msb(ram_msb_1), .q0(q0_1), .q_msb(q_msb_1)
  );

  logic [7:0] m_ram [16];
  logic [7:0] m_q;
  logic [7:0] p_y;
  logic [5:0] p_fl;
  bit         started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned u(input logic [7:0] v);
    return {24'd0, v};
  endfunction

  // Flags packed as {cout, ovr, z, f_msb, g_lo, p_lo}.
  task automatic eval(output logic [7:0] f, output logic [7:0] yv, output logic [5:0] fl);
    int unsigned r, s, x, yy, sum;
    logic [7:0]  fv;
    logic        co, ov, gl, pl;
    case (i[2:0])
      3'd0:    begin r = u(m_ram[a]); s = u(m_q);      end
      3'd1:    begin r = u(m_ram[a]); s = u(m_ram[b]); end
      3'd2:    begin r = 0;           s = u(m_q);      end
      3'd3:    begin r = 0;           s = u(m_ram[b]); end
      3'd4:    begin r = 0;           s = u(m_ram[a]); end
      3'd5:    begin r = u(d);        s = u(m_ram[a]); end
      3'd6:    begin r = u(d);        s = u(m_q);      end
      default: begin r = u(d);        s = 0;           end
    endcase
    co = 1'b0; ov = 1'b0; gl = 1'b1; pl = 1'b1;
    if (i[5:3] < 3'd3) begin
      x  = (i[5:3] == 3'd1) ? 255 - r : r;
      yy = (i[5:3] == 3'd2) ? 255 - s : s;
      sum = x + yy + u({7'd0, cin});
      fv  = 8'(sum % 256);
      co  = (sum > 255);
      ov  = ((x > 127) == (yy > 127)) && ((u(fv) > 127) != (x > 127));
      gl  = !(x + yy > 255);
      pl  = ((x | yy) != 255);
    end else begin
      case (i[5:3])
        3'd3:    fv = 8'(r | s);
        3'd4:    fv = 8'(r & s);
        3'd5:    fv = 8'((255 - r) & s);
        3'd6:    fv = 8'(r ^ s);
        default: fv = 8'(255 - (r ^ s));
      endcase
    end
    f  = fv;
    yv = (i[8:6] == 3'd2) ? m_ram[a] : fv;
    fl = {co, ov, (fv == 8'd0), fv[7], gl, pl};
  endtask

  // Compare at negedge, advance the model at posedge.
  initial begin
    logic [7:0] ef, ey;
    logic [5:0] efl;
    forever begin
      @(negedge cp);
      if (started) begin
        eval(ef, ey, efl);
        chk("y comb", 32'(y0), 32'(ey));
        chk("flags comb", 32'({cout0, ovr0, z0, fmsb0, glo0, plo0}), 32'(efl));
        chk("y pipe", 32'(y1), 32'(p_y));
        chk("flags pipe", 32'({cout1, ovr1, z1, fmsb1, glo1, plo1}), 32'(p_fl));
        if (i[8:7] == 2'b10) begin
          chk("ram0/q0 comb", 32'({ram0_0, q0_0}), 32'({ef[0], m_q[0]}));
          chk("ram0/q0 pipe", 32'({ram0_1, q0_1}), 32'({ef[0], m_q[0]}));
        end
        if (i[8:7] == 2'b11) begin
          chk("ram_msb/q_msb comb", 32'({ram_msb_0, q_msb_0}), 32'({ef[7], m_q[7]}));
          chk("ram_msb/q_msb pipe", 32'({ram_msb_1, q_msb_1}), 32'({ef[7], m_q[7]}));
        end
      end
      @(posedge cp);
      eval(ef, ey, efl);
      if (reset) begin
        foreach (m_ram[k]) m_ram[k] = 8'd0;
        m_q  = 8'd0;
        p_y  = 8'd0;
        p_fl = 6'b000011;
      end else begin
        p_y  = ey;
        p_fl = efl;
        if (iv) begin
          case (i[8:6])
            3'd0: m_q = ef;
            3'd2, 3'd3: m_ram[b] = ef;
            3'd4: begin m_ram[b] = {tb_ram_msb, ef[7:1]}; m_q = {tb_q_msb, m_q[7:1]}; end
            3'd5: m_ram[b] = {tb_ram_msb, ef[7:1]};
            3'd6: begin m_ram[b] = {ef[6:0], tb_ram0}; m_q = {m_q[6:0], tb_q0}; end
            3'd7: m_ram[b] = {ef[6:0], tb_ram0};
            default: ;
          endcase
        end
      end
      started = 1'b1;
    end
  end

  // pins = {ram_msb, q_msb, ram0, q0} as driven by the bench.
  task automatic issue(input logic rst, input logic v, input logic [8:0] ii, input logic [3:0] aa,
                       input logic [3:0] bb, input logic [7:0] dd, input logic cc,
                       input logic [3:0] pins);
    @(posedge cp);
    #1;
    reset = rst; iv = v; i = ii; a = aa; b = bb; d = dd; cin = cc;
    {tb_ram_msb, tb_q_msb, tb_ram0, tb_q0} = pins;
    @(negedge cp);
  endtask

  initial begin
    reset = 1'b1; iv = 1'b1; cin = 1'b0; oe = 1'b0; i = 9'h05C; d = 8'd0; a = 4'd0; b = 4'd0;
    {tb_ram_msb, tb_q_msb, tb_ram0, tb_q0} = 4'b0000;

    // Reset state: read R5 through ZA/OR/NOP.
    issue(0, 1, 9'h05C, 5, 0, 8'h00, 0, 4'b0000);
    chk("t1 y", 32'(y0), 32'h00);
    chk("t1 z", 32'(z0), 32'h1);
    chk("t1 cout", 32'(cout0), 32'h0);

    // Write D into R3, read it back.
    issue(0, 1, 9'h0C7, 0, 3, 8'h5A, 0, 4'b0000);
    chk("t2 y", 32'(y0), 32'h5A);
    issue(0, 1, 9'h05C, 3, 0, 8'h00, 0, 4'b0000);
    chk("t2 readback", 32'(y0), 32'h5A);

    // Signed overflow 0x7F + 0x01.
    issue(0, 1, 9'h0C7, 0, 5, 8'h7F, 0, 4'b0000);
    issue(0, 1, 9'h0C7, 0, 6, 8'h01, 0, 4'b0000);
    issue(0, 1, 9'h0C1, 5, 6, 8'h00, 0, 4'b0000);
    chk("t3 y", 32'(y0), 32'h80);
    chk("t3 ovr", 32'(ovr0), 32'h1);
    chk("t3 cout", 32'(cout0), 32'h0);
    chk("t3 f_msb", 32'(fmsb0), 32'h1);
    chk("t3 z", 32'(z0), 32'h0);
    issue(0, 1, 9'h05C, 6, 0, 8'h00, 0, 4'b0000);
    chk("t3 readback R6", 32'(y0), 32'h80);

    // Down shift of RAM and Q.
    issue(0, 1, 9'h007, 0, 0, 8'h03, 0, 4'b0000);
    issue(0, 1, 9'h107, 0, 2, 8'h81, 0, 4'b1000);
    chk("t4 ram0", 32'(ram0_0), 32'h1);
    chk("t4 q0", 32'(q0_0), 32'h1);
    chk("t4 y", 32'(y0), 32'h81);
    issue(0, 1, 9'h05C, 2, 0, 8'h00, 0, 4'b0000);
    chk("t4 readback R2", 32'(y0), 32'hC0);
    issue(0, 1, 9'h05A, 0, 0, 8'h00, 0, 4'b0000);
    chk("t4 readback Q", 32'(y0), 32'h01);

    // Invalid instruction must not write.
    issue(0, 0, 9'h0C7, 0, 4, 8'h5A, 0, 4'b0000);
    chk("t5 y", 32'(y0), 32'h5A);
    issue(0, 1, 9'h05C, 4, 0, 8'h00, 0, 4'b0000);
    chk("t5 readback R4", 32'(y0), 32'h00);

    // Remaining functions, RAMA, up shifts and a gated Q shift; model-checked only.
    issue(0, 1, 9'h049, 5, 6, 8'h00, 1, 4'b0000);
    issue(0, 1, 9'h091, 6, 7, 8'h00, 1, 4'b0000);
    issue(0, 1, 9'h065, 5, 0, 8'hF0, 0, 4'b0000);
    issue(0, 1, 9'h06E, 0, 0, 8'h0F, 0, 4'b0000);
    issue(0, 1, 9'h071, 5, 6, 8'h00, 0, 4'b0000);
    issue(0, 1, 9'h078, 6, 0, 8'h00, 0, 4'b0000);
    issue(0, 1, 9'h187, 0, 8, 8'h81, 0, 4'b0010);
    issue(0, 1, 9'h1DB, 0, 8, 8'h00, 0, 4'b0001);
    issue(0, 1, 9'h15B, 0, 8, 8'h00, 0, 4'b0100);
    issue(0, 0, 9'h187, 0, 9, 8'hC3, 0, 4'b0011);
    issue(0, 1, 9'h05A, 0, 0, 8'h00, 0, 4'b0000);
    issue(0, 1, 9'h0CF, 0, 10, 8'hFF, 1, 4'b0000);
    issue(0, 1, 9'h003, 1, 3, 8'h00, 1, 4'b0000);
    issue(0, 1, 9'h00B, 0, 3, 8'h00, 1, 4'b0000);

    // Pipelined output and reset beating a simultaneous write.
    issue(0, 1, 9'h0C7, 0, 3, 8'h5A, 0, 4'b0000);
    issue(1, 1, 9'h0C7, 0, 3, 8'hFF, 0, 4'b0000);
    chk("t6 y pipe latency", 32'(y1), 32'h5A);
    issue(0, 1, 9'h05C, 3, 0, 8'h00, 0, 4'b0000);
    chk("t6 y pipe reset", 32'(y1), 32'h00);
    chk("t6 p_lo pipe reset", 32'(plo1), 32'h1);
    chk("t6 g_lo pipe reset", 32'(glo1), 32'h1);
    chk("t6 R3 after reset", 32'(y0), 32'h00);
    issue(0, 1, 9'h05C, 3, 0, 8'h00, 0, 4'b0000);
    chk("t6 R3 pipe readback", 32'(y1), 32'h00);

    @(posedge cp);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/am2901_slice_n.md
Name: am2901_slice_n

Overview:
- Parametrised successor of the 4-bit Am2901 bit-slice: a WIDTH-bit ALU, a 2**ADDR_W-entry dual-read register file, a Q register and up/down shifters, all in one module.
- Adds behaviour the 4-bit slice lacks: synchronous reset of all state, an instruction-valid write gate, and an optional registered-output pipeline stage.
- Keeps the 9-bit opcode semantics (source/function/destination) so existing microcode runs unchanged.

Parameters:
- WIDTH, 8, datapath width; legal 2..32.
- ADDR_W, 4, register address width; register file has 2**ADDR_W entries.
- PIPE, 0, 0 = combinational y/flags; 1 = y and flags registered one cycle.

Ports:
- cp  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- i  input  9  opcode: i[2:0] source, i[5:3] function, i[8:6] destination.
- iv  input  1  instruction valid; 0 suppresses all RAM/Q writes.
- cin  input  1  ALU carry-in.
- d  input  WIDTH  direct data.
- a, b  input  ADDR_W  read addresses; b is also the write address.
- oe  input  1  active-low output enable for y.
- y  output  WIDTH  tristate data out.
- cout, ovr, z, f_msb  output  1 each  carry-out, overflow, F==0, F[WIDTH-1].
- g_lo, p_lo  output  1 each  active-low group generate/propagate.
- ram0, ram_msb, q0, q_msb  inout  1 each  shifter ends.

Behaviour:
- Reads combinational: A=RAM[a], B=RAM[b].
- Source (R,S): 0 A,Q; 1 A,B; 2 0,Q; 3 0,B; 4 0,A; 5 D,A; 6 D,Q; 7 D,0.
- Function F:
  - 0: R+S+cin
  - 1: S+~R+cin
  - 2: R+~S+cin
  - 3: R|S
  - 4: R&S
  - 5: ~R&S
  - 6: R^S
  - 7: ~(R^S)
  - Arithmetic sum is WIDTH+1 bits; cout = bit WIDTH.
- Flags:
  - ovr = carry into MSB XOR cout.
  - Lookahead uses operands X,Y as actually added (inverted operand for fn 1/2): p=X|Y, g=X&Y. p_lo=~&p. g_lo = ~(group generate over WIDTH).
  - Logic functions (3-7): cout=0, ovr=0, g_lo=1, p_lo=1.
  - z = (F==0) for every function.
- Destination (iv=1; iv=0 blocks every write below, y and flags unaffected):
  - 0 QREG: Q<=F; y=F.
  - 1 NOP: no write; y=F.
  - 2 RAMA: RAM[b]<=F; y=A.
  - 3 RAMF: RAM[b]<=F; y=F.
  - 4 RAMQD: RAM[b]<={ram_msb,F[W-1:1]}; Q<={q_msb,Q[W-1:1]}; y=F.
  - 5 RAMD: RAM[b] as dest 4; Q unchanged; y=F.
  - 6 RAMQU: RAM[b]<={F[W-2:0],ram0}; Q<={Q[W-2:0],q0}; y=F.
  - 7 RAMU: RAM[b] as dest 6; Q unchanged; y=F.
- Shifter pin drive (independent of iv and oe):
  - Dest 4/5: drive ram0=F[0], q0=Q[0]; ram_msb and q_msb are inputs.
  - Dest 6/7: drive ram_msb=F[W-1], q_msb=Q[W-1]; ram0 and q0 are inputs.
  - Other dests: all four pins Z.
  - Undriven inputs read as X; the bench must drive them.
- y driven when oe=0, else Z.
- PIPE=1: y value, cout, ovr, z, f_msb, g_lo, p_lo captured at cp edge and presented next cycle; oe stays combinational. RAM/Q writes still same-cycle, so latency = 1 for outputs only.
- Reset:
  - All RAM entries and Q <=0.
  - Pipeline regs <=0, except g_lo/p_lo <=1.
  - Reset beats any simultaneous write, including mid-instruction.
  - PIPE=0 outputs stay combinational during reset.
- Same-address read/write: a==b write returns old data this cycle, new data next cycle.
- No write when b out of range is impossible: full decode.

Test Plan (WIDTH=8, ADDR_W=4, PIPE=0 unless stated; oe=0, iv=1):
1. reset=1 one cycle; then i=0x05C (ZA, OR, NOP), a=5 -> y=0x00, z=1, cout=0.
2. d=0x5A, i=0x0C7 (DZ, ADD, RAMF), cin=0, b=3 -> y=0x5A. Next cycle i=0x05C, a=3 -> y=0x5A.
3. Load R5=0x7F, R6=0x01; i=0x0C1 (AB, ADD, RAMF), a=5, b=6, cin=0 -> y=0x80, ovr=1, cout=0, f_msb=1, z=0. Next read of R6 = 0x80.
4. Q=0x03, d=0x81, i=0x107 (DZ, ADD, RAMQD), b=2, ram_msb=1, q_msb=0 -> ram0=1, q0=1 driven, y=0x81. After edge R2=0xC0, Q=0x01.
5. iv=0 with test 2 stimulus, b=4 -> y=0x5A; R4 stays 0x00 on readback.
6. PIPE=1: test 2 -> y=0x5A appears one cycle after issue. Assert reset in the cycle after issue -> y=0x00, p_lo=1, g_lo=1 next cycle; R3 readback 0x00.
